// File: rtl/gray_pkg.sv
// Shared definitions for the Gray counter link: default width, receiver states,
// move classification and the 3-bit Gray code table used by both ends.
package gray_pkg;

  localparam int GRAY_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MV_HOLD = 2'd0,
    MV_FWD  = 2'd1,
    MV_BWD  = 2'd2,
    MV_JUMP = 2'd3
  } move_t;

  // Gray encodings of binary 0..7, in counting order
  localparam logic [GRAY_W-1:0] S0 = 3'b000;
  localparam logic [GRAY_W-1:0] S1 = 3'b001;
  localparam logic [GRAY_W-1:0] S2 = 3'b011;
  localparam logic [GRAY_W-1:0] S3 = 3'b010;
  localparam logic [GRAY_W-1:0] S4 = 3'b110;
  localparam logic [GRAY_W-1:0] S5 = 3'b111;
  localparam logic [GRAY_W-1:0] S6 = 3'b101;
  localparam logic [GRAY_W-1:0] S7 = 3'b100;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin #(
  parameter int W = 3
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_rx.sv
// Gray-coded position receiver: decodes sampled Gray words, tracks +/-1 moves,
// flags forward wrap and illegal jumps. Backward moves need GRAY_RX_DOWN_EN.
module gray_rx
  import gray_pkg::*;
#(
  parameter int W = GRAY_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         In_valid,
  input  logic [W-1:0] Gray,
  output logic [W-1:0] Binary,
  output logic         Locked,
  output logic         Step,
  output logic         Down,
  output logic         Overflow,
  output logic         Error
);

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ONES = '1;

  state_t       state;
  logic [W-1:0] cand;
  logic [W-1:0] diff;
  move_t        move;

  function automatic move_t classify(input logic [W-1:0] d);
    if (d == '0)        return MV_HOLD;
    else if (d == ONE)  return MV_FWD;
    else if (d == ONES) return MV_BWD;
    else                return MV_JUMP;
  endfunction

  gray2bin #(.W(W)) u_decode (
    .gray (Gray),
    .bin  (cand)
  );

  // Modular distance from the last accepted value decides the move type
  assign diff = cand - Binary;
  assign move = classify(diff);

`ifndef GRAY_RX_DOWN_EN
  assign Down = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      Binary   <= '0;
      Locked   <= 1'b0;
      Step     <= 1'b0;
      Overflow <= 1'b0;
      Error    <= 1'b0;
`ifdef GRAY_RX_DOWN_EN
      Down     <= 1'b0;
`endif
    end else begin
      Step <= 1'b0;
`ifdef GRAY_RX_DOWN_EN
      Down <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (In_valid) begin
            Binary <= cand;
            Locked <= 1'b1;
            state  <= TRACK;
          end
        end
        TRACK: begin
          if (In_valid) begin
            unique case (move)
              MV_HOLD: ;
              MV_FWD: begin
                Binary <= cand;
                Step   <= 1'b1;
                if (Binary == ONES && cand == '0) Overflow <= 1'b1;
              end
`ifdef GRAY_RX_DOWN_EN
              MV_BWD: begin
                Binary <= cand;
                Step   <= 1'b1;
                Down   <= 1'b1;
              end
`endif
              default: begin
                Error  <= 1'b1;
                Locked <= 1'b0;
                state  <= FAULT;
              end
            endcase
          end
        end
        default: ;  // FAULT holds until Reset
      endcase
    end
  end

endmodule
